// File: rtl/fruit_launcher.sv
// Game-flow controller: spawns one fruit at a time and runs its flight.
// It also keeps the cut and life counts. Define LAUNCHER_BOMB_EN to enable bomb objects.
module fruit_launcher #(
  parameter int SPAWN_GAP      = 60,
  parameter int SPAWN_GAP_MIN  = 15,
  parameter int LIVES          = 3,
  parameter int Y_MAX          = 479,
  parameter int VY_BASE        = 12,
  parameter int FLIGHT_TIMEOUT = 240
) (
  input  logic       frame_clk_i,
  input  logic       Reset_i,
  input  logic       start_i,
  input  logic [7:0] rand_num_i,
  input  logic [9:0] fruitY_i,
  input  logic [9:0] fruitS_i,
  input  logic       slice_hit_i,
  output logic       new_fruit_o,
  output logic       move_fruit_o,
  output logic [9:0] launch_x_o,
  output logic [9:0] launch_vx_o,
  output logic [9:0] launch_vy_o,
  output logic       launch_bomb_o,
  output logic [7:0] number_of_fruits_cut_o,
  output logic [1:0] lives_o,
  output logic       game_over_o
);

`ifdef LAUNCHER_BOMB_EN
  localparam bit BOMB_EN = 1'b1;
`else
  localparam bit BOMB_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_COOLDOWN, S_LAUNCH, S_FLIGHT, S_OVER
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  gap_q, gap_d;
  logic [7:0]  timer_q, timer_d;
  logic        risen_q, risen_d;
  logic [7:0]  cut_q, cut_d;
  logic [1:0]  lives_q, lives_d;
  logic [9:0]  x_q, x_d, vx_q, vx_d, vy_q, vy_d;
  logic        bomb_q, bomb_d;
  logic        new_fruit_q, move_q, over_q;

  function automatic logic [7:0] gap_for(input logic [7:0] cut);
    int g;
    g = SPAWN_GAP - int'(cut >> 2);
    if (g < SPAWN_GAP_MIN) g = SPAWN_GAP_MIN;
    return 8'(g);
  endfunction

  logic [2:0]  level;
  logic [11:0] rise_thr;
  logic        rise_now, low_edge, miss;
  logic [7:0]  cut_inc;

  assign level    = (cut_q >= 8'd56) ? 3'd7 : cut_q[5:3];
  // A negative threshold (very large fruit) means the fruit can never count as risen.
  assign rise_thr = 12'(Y_MAX) - {1'b0, fruitS_i, 1'b0};
  assign rise_now = !rise_thr[11] && ({2'b00, fruitY_i} < rise_thr);
  assign low_edge = (fruitY_i >= 10'(Y_MAX)) && (fruitY_i < 10'd960);
  assign miss     = (risen_q && low_edge) || (timer_q == 8'(FLIGHT_TIMEOUT));
  assign cut_inc  = (cut_q == 8'hFF) ? cut_q : cut_q + 8'd1;

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    timer_d = timer_q;
    risen_d = risen_q;
    cut_d   = cut_q;
    lives_d = lives_q;
    x_d     = x_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    bomb_d  = bomb_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_COOLDOWN;
          gap_d   = gap_for(cut_q);
        end
      end
      S_COOLDOWN: begin
        if (gap_q == 8'd0) begin
          state_d = S_LAUNCH;
          x_d     = 10'd64 + {1'b0, rand_num_i, 1'b0};
          vx_d    = {6'd0, rand_num_i[3:0]} - 10'd8;
          vy_d    = 10'd0 - (10'(VY_BASE) + {7'd0, level});
          bomb_d  = BOMB_EN && (&rand_num_i[7:5]);
          timer_d = 8'd0;
          risen_d = 1'b0;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      S_LAUNCH: state_d = S_FLIGHT;
      S_FLIGHT: begin
        if (timer_q != 8'hFF) timer_d = timer_q + 8'd1;
        if (rise_now) risen_d = 1'b1;
        // A cut in the same frame as a miss takes priority.
        if (slice_hit_i) begin
          if (BOMB_EN && bomb_q) begin
            lives_d = 2'd0;
            state_d = S_OVER;
          end else begin
            cut_d   = cut_inc;
            gap_d   = gap_for(cut_inc);
            state_d = S_COOLDOWN;
          end
        end else if (miss) begin
          if (BOMB_EN && bomb_q) begin
            gap_d   = gap_for(cut_q);
            state_d = S_COOLDOWN;
          end else if (lives_q <= 2'd1) begin
            lives_d = 2'd0;
            state_d = S_OVER;
          end else begin
            lives_d = lives_q - 2'd1;
            gap_d   = gap_for(cut_q);
            state_d = S_COOLDOWN;
          end
        end
      end
      S_OVER: begin
        if (start_i) begin
          cut_d   = 8'd0;
          lives_d = 2'(LIVES);
          gap_d   = gap_for(8'd0);
          state_d = S_COOLDOWN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge frame_clk_i) begin
    if (!Reset_i) begin
      state_q     <= S_IDLE;
      gap_q       <= 8'd0;
      timer_q     <= 8'd0;
      risen_q     <= 1'b0;
      cut_q       <= 8'd0;
      lives_q     <= 2'(LIVES);
      x_q         <= 10'd0;
      vx_q        <= 10'd0;
      vy_q        <= 10'd0;
      bomb_q      <= 1'b0;
      new_fruit_q <= 1'b0;
      move_q      <= 1'b0;
      over_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      timer_q     <= timer_d;
      risen_q     <= risen_d;
      cut_q       <= cut_d;
      lives_q     <= lives_d;
      x_q         <= x_d;
      vx_q        <= vx_d;
      vy_q        <= vy_d;
      bomb_q      <= bomb_d;
      new_fruit_q <= (state_d == S_LAUNCH);
      move_q      <= (state_d == S_FLIGHT);
      over_q      <= (state_d == S_OVER);
    end
  end

  assign new_fruit_o            = new_fruit_q;
  assign move_fruit_o           = move_q;
  assign launch_x_o             = x_q;
  assign launch_vx_o            = vx_q;
  assign launch_vy_o            = vy_q;
  assign launch_bomb_o          = bomb_q;
  assign number_of_fruits_cut_o = cut_q;
  assign lives_o                = lives_q;
  assign game_over_o            = over_q;

endmodule

// File: tb/tb_fruit_launcher.sv
// Bench for fruit_launcher: frame-level game model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_fruit_launcher;
  localparam int LIVES = 3;
  localparam int P_IDLE = 0, P_COOL = 1, P_LAUNCH = 2, P_FLIGHT = 3, P_OVER = 4;

  logic       clk = 1'b0;
  logic       rst_b, start, slice_hit;
  logic [7:0] rnd;
  logic [9:0] fy, fs;
  logic       new_fruit, move_fruit, launch_bomb, game_over;
  logic [9:0] launch_x, launch_vx, launch_vy;
  logic [7:0] cut;
  logic [1:0] lives;

  always #5 clk = ~clk;

  fruit_launcher dut (
    .frame_clk_i(clk), .Reset_i(rst_b), .start_i(start), .rand_num_i(rnd),
    .fruitY_i(fy), .fruitS_i(fs), .slice_hit_i(slice_hit),
    .new_fruit_o(new_fruit), .move_fruit_o(move_fruit),
    .launch_x_o(launch_x), .launch_vx_o(launch_vx), .launch_vy_o(launch_vy),
    .launch_bomb_o(launch_bomb), .number_of_fruits_cut_o(cut),
    .lives_o(lives), .game_over_o(game_over)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Game model in frame numbers: launch and timeout are absolute frame deadlines.
  int  m_frame = 0, m_phase = P_IDLE, m_launch_at = 0, m_flight_start = 0;
  int  m_cut = 0, m_lives = LIVES, m_x = 0, m_vx = 0, m_vy = 0, m_age;
  bit  m_risen = 0, m_bomb = 0, m_valid = 0, m_hit, m_miss;

  function automatic int gap_of(input int c);
    return (60 - c / 4 < 15) ? 15 : 60 - c / 4;
  endfunction

  always @(posedge clk) begin
    m_frame++;
    if (!rst_b) begin
      m_phase = P_IDLE; m_cut = 0; m_lives = LIVES; m_x = 0; m_vx = 0; m_vy = 0;
      m_bomb = 0; m_risen = 0; m_valid = 1;
    end else if (m_valid) begin
      case (m_phase)
        P_IDLE: if (start) begin m_phase = P_COOL; m_launch_at = m_frame + gap_of(m_cut) + 1; end
        P_COOL: if (m_frame == m_launch_at) begin
          m_phase = P_LAUNCH;
          m_x  = 64 + 2 * int'(rnd);
          m_vx = int'(rnd % 16) - 8;
          m_vy = -(12 + ((m_cut / 8 > 7) ? 7 : m_cut / 8));
`ifdef LAUNCHER_BOMB_EN
          m_bomb = (rnd >= 8'hE0);
`else
          m_bomb = 0;
`endif
          m_risen = 0;
        end
        P_LAUNCH: begin m_phase = P_FLIGHT; m_flight_start = m_frame; end
        P_FLIGHT: begin
          m_age  = m_frame - m_flight_start - 1;
          m_hit  = slice_hit;
          m_miss = (m_risen && fy >= 479 && fy < 960) || (m_age == 240);
          if (m_hit) begin
            if (m_bomb) begin m_lives = 0; m_phase = P_OVER; end
            else begin
              m_cut = (m_cut == 255) ? 255 : m_cut + 1;
              m_phase = P_COOL; m_launch_at = m_frame + gap_of(m_cut) + 1;
            end
          end else if (m_miss) begin
            if (!m_bomb) m_lives--;
            if (m_lives == 0) m_phase = P_OVER;
            else begin m_phase = P_COOL; m_launch_at = m_frame + gap_of(m_cut) + 1; end
          end
          if (479 - 2 * int'(fs) > int'(fy)) m_risen = 1;
        end
        P_OVER: if (start) begin
          m_cut = 0; m_lives = LIVES;
          m_phase = P_COOL; m_launch_at = m_frame + gap_of(0) + 1;
        end
        default: m_phase = P_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("new_fruit", new_fruit, m_phase == P_LAUNCH);
      chk("move_fruit", move_fruit, m_phase == P_FLIGHT);
      chk("game_over", game_over, m_phase == P_OVER);
      chk("lives", lives, m_lives);
      chk("cut", cut, m_cut);
      chk("launch_x", launch_x, m_x & 32'h3FF);
      chk("launch_vx", launch_vx, m_vx & 32'h3FF);
      chk("launch_vy", launch_vy, m_vy & 32'h3FF);
      chk("launch_bomb", launch_bomb, m_bomb);
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_move();
    int n = 0;
    while (move_fruit !== 1'b1 && n < 300) begin tick(); n++; end
    chk("wait_flight", move_fruit, 1);
  endtask

  initial begin
    int n;
    rst_b = 0; start = 0; slice_hit = 0; rnd = 8'h00; fy = 10'd479; fs = 10'd10;
    tick(); tick();
    chk("rst_new_fruit", new_fruit, 0);
    chk("rst_move", move_fruit, 0);
    chk("rst_lives", lives, 3);
    chk("rst_game_over", game_over, 0);
    chk("rst_cut", cut, 0);
    chk("rst_launch_x", launch_x, 0);
    rst_b = 1;

    // First launch: 61 edges after start, values from rand 0x25.
    rnd = 8'h25; start = 1; tick(); start = 0;
    n = 0;
    while (new_fruit !== 1'b1 && n < 200) begin tick(); n++; end
    chk("start_to_launch", n, 61);
    chk("x_138", launch_x, 138);
    chk("vx_m3", launch_vx, 10'h3FD);
    chk("vy_m12", launch_vy, 10'h3F4);
    tick();
    chk("new_fruit_1cyc", new_fruit, 0);
    chk("flight_move", move_fruit, 1);

    // Rise then fall below the bottom edge: miss.
    fy = 10'd479; tick(); fy = 10'd300; tick(); fy = 10'd480; tick();
    chk("miss_lives", lives, 2);
    chk("miss_cooldown", move_fruit, 0);
    fy = 10'd479;

    for (int i = 1; i <= 40; i++) begin
      wait_move();
      slice_hit = 1; fy = 10'd300; tick(); slice_hit = 0; fy = 10'd479;
      if (i == 40) begin
        chk("cut_40", cut, 40);
        n = 0;
        while (new_fruit !== 1'b1 && n < 200) begin tick(); n++; end
        chk("gap_50", n, 51);
        chk("vy_m17", launch_vy, 10'h3EF);
      end
    end

    // Hit and miss in the same frame.
    wait_move();
    fy = 10'd300; tick(); fy = 10'd480; slice_hit = 1; tick(); slice_hit = 0;
    chk("hitmiss_cut", cut, 41);
    chk("hitmiss_lives", lives, 2);
    fy = 10'd479;

    // Never rises: forced miss on timeout.
    wait_move();
    n = 0;
    while (move_fruit === 1'b1 && n < 400) begin tick(); n++; end
    chk("timeout_frames", n, 241);
    chk("timeout_lives", lives, 1);

    wait_move();
    fy = 10'd300; tick(); fy = 10'd480; tick(); fy = 10'd479;
    chk("over_flag", game_over, 1);
    chk("over_lives", lives, 0);
    chk("over_move", move_fruit, 0);
    tick(); tick();

    start = 1; tick(); start = 0;
    chk("restart_lives", lives, 3);
    chk("restart_cut", cut, 0);
    chk("restart_over", game_over, 0);

    rnd = 8'hE0;
    wait_move();
`ifdef LAUNCHER_BOMB_EN
    chk("bomb_flag", launch_bomb, 1);
`else
    chk("bomb_flag", launch_bomb, 0);
`endif
    slice_hit = 1; tick(); slice_hit = 0;
`ifdef LAUNCHER_BOMB_EN
    chk("bomb_hit_over", game_over, 1);
    chk("bomb_hit_cut", cut, 0);
`else
    chk("bomb_hit_over", game_over, 0);
    chk("bomb_hit_cut", cut, 1);
`endif

    if (game_over === 1'b1) begin start = 1; tick(); start = 0; end
    wait_move();
    rst_b = 0; tick();
    chk("midflight_rst_move", move_fruit, 0);
    chk("midflight_rst_lives", lives, 3);
    rst_b = 1; tick();

    for (int k = 0; k < 4000; k++) begin
      rnd       = 8'($urandom);
      start     = ($urandom_range(0, 99) < 3);
      slice_hit = ($urandom_range(0, 99) < 4);
      rst_b     = !($urandom_range(0, 999) < 2);
      case ($urandom_range(0, 9))
        0, 1, 2, 3: fy = 10'd300;
        4, 5, 6:    fy = 10'd480;
        7:          fy = 10'd970;
        8:          fy = 10'd479;
        default:    fy = 10'($urandom_range(0, 1023));
      endcase
      fs = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 300)) : 10'($urandom_range(0, 40));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
